// File: rtl/prescaler_multi_if.sv
// Configuration write port of the multi-channel prescaler.
// The master drives one channel's divisor/mode write per strobe.
interface prescaler_multi_if #(
   parameter int WIDTH    = 16,
   parameter int SEL_BITS = 2
);
   logic                cfg_we;
   logic [SEL_BITS-1:0] cfg_sel;
   logic [WIDTH-1:0]    cfg_div;
   logic                cfg_mode;

   modport master (
      output cfg_we,
      output cfg_sel,
      output cfg_div,
      output cfg_mode
   );

   modport slave (
      input cfg_we,
      input cfg_sel,
      input cfg_div,
      input cfg_mode
   );
endinterface

// File: rtl/prescaler_multi.sv
// Multi-channel programmable prescaler: periodic or one-shot tick per channel.
// Define PRESCALER_CASCADE_EN to clock channel i>0 from tick[i-1].
module prescaler_multi #(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 16,
   parameter int SEL_BITS    = 2,
   parameter int DEFAULT_DIV = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   run,
   input  logic [CHANNELS-1:0]   restart,
   prescaler_multi_if.slave      cfg,
   output logic [CHANNELS-1:0]   tick,
   output logic [CHANNELS-1:0]   busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_e;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_e           state_q, state_d;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] div_q, div_d;
      logic             mode_q, mode_d;
      logic             tick_q, tick_d;
      logic             busy_q, busy_d;
      logic             wr;
      logic             gate;
      logic             act;

`ifdef PRESCALER_CASCADE_EN
      if (i == 0) begin : g_src
         assign gate = 1'b1;
      end else begin : g_cas
         assign gate = tick[i-1];
      end
`else
      assign gate = 1'b1;
`endif

      // Out-of-range selects never match any channel index.
      assign wr  = cfg.cfg_we && (cfg.cfg_sel == SEL_BITS'(i));
      assign act = run[i] && (state_q == COUNT) && gate;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         div_d   = div_q;
         mode_d  = mode_q;
         tick_d  = 1'b0;
         busy_d  = busy_q;
         if (wr) begin
            div_d   = cfg.cfg_div;
            mode_d  = cfg.cfg_mode;
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = cfg.cfg_mode ? IDLE : COUNT;
         end else if (restart[i]) begin
            cnt_d   = '0;
            state_d = COUNT;
            busy_d  = mode_q;
         end else if (act) begin
            if (cnt_q == div_q) begin
               tick_d = 1'b1;
               cnt_d  = '0;
               if (mode_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else if (!mode_q && state_q == IDLE) begin
            // Periodic channels only sit in IDLE right after reset.
            state_d = COUNT;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= WIDTH'(DEFAULT_DIV);
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
         end
      end

      assign tick[i] = tick_q;
      assign busy[i] = busy_q;
   end

endmodule

// File: tb/tb_prescaler_multi.sv
// Directed bench for prescaler_multi (4 channels, 3-bit select).
// Build with PRESCALER_CASCADE_EN to run the cascade scenario instead.
module tb_prescaler_multi;

   logic       clk;
   logic       rst;
   logic [3:0] run;
   logic [3:0] restart;
   logic [3:0] tick;
   logic [3:0] busy;
   int         n_chk;
   int         n_fail;

   prescaler_multi_if #(.WIDTH(16), .SEL_BITS(3)) cfg_bus ();

   prescaler_multi #(
      .CHANNELS   (4),
      .WIDTH      (16),
      .SEL_BITS   (3),
      .DEFAULT_DIV(1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .restart(restart),
      .cfg    (cfg_bus),
      .tick   (tick),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   typedef struct {
      logic        rst;
      logic [3:0]  run;
      logic [3:0]  rs;
      logic        we;
      logic [2:0]  sel;
      logic [15:0] div;
      logic        mode;
      logic [3:0]  et;
      logic [3:0]  eb;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t v(input logic r, input logic we,
                              input logic [2:0] s, input logic [15:0] d,
                              input logic m, input logic [3:0] et);
      vec_t x;
      x.rst  = r;
      x.run  = 4'hF;
      x.rs   = 4'h0;
      x.we   = we;
      x.sel  = s;
      x.div  = d;
      x.mode = m;
      x.et   = et;
      x.eb   = 4'h0;
      return x;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] s, input logic [15:0] d,
                     input logic m);
      cfg_bus.cfg_we   = 1'b1;
      cfg_bus.cfg_sel  = s;
      cfg_bus.cfg_div  = d;
      cfg_bus.cfg_mode = m;
      step();
      cfg_bus.cfg_we   = 1'b0;
   endtask

   // One-shot ch1 with div=3 after its restart edge.
   task automatic os_shot(input string tag);
      for (int k = 1; k <= 6; k++) begin
         step();
         chk({tag, "_tick1"}, tick[1], k == 4);
         chk({tag, "_busy1"}, busy[1], k <= 3);
      end
   endtask

   initial begin
      n_chk            = 0;
      n_fail           = 0;
      rst              = 1'b1;
      run              = 4'h0;
      restart          = 4'h0;
      cfg_bus.cfg_we   = 1'b0;
      cfg_bus.cfg_sel  = '0;
      cfg_bus.cfg_div  = '0;
      cfg_bus.cfg_mode = 1'b0;

`ifdef PRESCALER_CASCADE_EN
      step();
      step();
      chk("rst_tick", tick, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      run = 4'hF;
      wr(3'd1, 16'd2, 1'b0);
      wr(3'd0, 16'd1, 1'b0);
      for (int k = 1; k <= 30; k++) begin
         step();
         chk("cas_tick0", tick[0], (k % 2) == 0);
         chk("cas_tick1", tick[1], (k >= 7) && ((k - 7) % 6 == 0));
      end
`else
      // Row 0: reset with a pending write, which must be ignored.
      tbl[0]  = v(1, 1, 3'd2, 16'd9, 1'b1, 4'h0);
      tbl[1]  = v(0, 0, 3'd0, 16'd0, 1'b0, 4'h0);
      tbl[2]  = v(0, 0, 3'd0, 16'd0, 1'b0, 4'h0);
      tbl[3]  = v(0, 0, 3'd0, 16'd0, 1'b0, 4'hF);
      tbl[4]  = v(0, 0, 3'd0, 16'd0, 1'b0, 4'h0);
      tbl[5]  = v(0, 0, 3'd0, 16'd0, 1'b0, 4'hF);
      tbl[6]  = v(0, 1, 3'd2, 16'd4, 1'b0, 4'h0);
      tbl[7]  = v(0, 0, 3'd0, 16'd0, 1'b0, 4'hB);
      tbl[8]  = v(0, 0, 3'd0, 16'd0, 1'b0, 4'h0);
      tbl[9]  = v(0, 0, 3'd0, 16'd0, 1'b0, 4'hB);
      tbl[10] = v(0, 0, 3'd0, 16'd0, 1'b0, 4'h0);
      tbl[11] = v(0, 0, 3'd0, 16'd0, 1'b0, 4'hF);
      tbl[12] = v(0, 0, 3'd0, 16'd0, 1'b0, 4'h0);
      tbl[13] = v(0, 0, 3'd0, 16'd0, 1'b0, 4'hB);
      tbl[14] = v(0, 0, 3'd0, 16'd0, 1'b0, 4'h0);
      tbl[15] = v(0, 0, 3'd0, 16'd0, 1'b0, 4'hB);
      tbl[16] = v(0, 0, 3'd0, 16'd0, 1'b0, 4'h4);
      tbl[17] = v(0, 0, 3'd0, 16'd0, 1'b0, 4'hB);

      for (int i = 0; i < 18; i++) begin
         rst              = tbl[i].rst;
         run              = tbl[i].run;
         restart          = tbl[i].rs;
         cfg_bus.cfg_we   = tbl[i].we;
         cfg_bus.cfg_sel  = tbl[i].sel;
         cfg_bus.cfg_div  = tbl[i].div;
         cfg_bus.cfg_mode = tbl[i].mode;
         step();
         chk($sformatf("tbl%0d_tick", i), tick, tbl[i].et);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      end
      cfg_bus.cfg_we = 1'b0;

      // One-shot ch1, div=3.
      wr(3'd1, 16'd3, 1'b1);
      chk("os_wr_tick1", tick[1], 0);
      chk("os_wr_busy1", busy[1], 0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("os_idle_tick1", tick[1], 0);
         chk("os_idle_busy1", busy[1], 0);
      end
      restart = 4'b0010;
      step();
      restart = 4'h0;
      chk("os_arm_busy1", busy[1], 1);
      os_shot("os1");
      // Re-arm while busy: one tick, four edges after the last restart.
      restart = 4'b0010;
      step();
      restart = 4'h0;
      step();
      step();
      chk("os_mid_busy1", busy[1], 1);
      restart = 4'b0010;
      step();
      restart = 4'h0;
      chk("os_rearm_tick1", tick[1], 0);
      os_shot("os2");

      // Ch0 div=5 with a 3-cycle pause, then restart on terminal count.
      wr(3'd0, 16'd5, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         run[0] = !(k >= 3 && k <= 5);
         step();
         chk("pause_tick0", tick[0], k == 9);
      end
      run = 4'hF;
      for (int k = 10; k <= 21; k++) begin
         restart[0] = (k == 15);
         step();
         chk("rsterm_tick0", tick[0], k == 21);
      end
      restart = 4'h0;
      wr(3'd5, 16'd0, 1'b1);
      chk("bad_sel_tick0", tick[0], 0);
      chk("bad_sel_busy", busy, 0);
      for (int k = 23; k <= 27; k++) begin
         step();
         chk("bad_sel_tick0", tick[0], k == 27);
         chk("bad_sel_tick1", tick[1], 0);
      end

      // Write beats same-cycle restart on ch3; ch1 restart still lands.
      restart = 4'b1010;
      wr(3'd3, 16'd2, 1'b1);
      restart = 4'h0;
      chk("wr_rs_busy3", busy[3], 0);
      chk("wr_rs_busy1", busy[1], 1);
      chk("wr_rs_tick3", tick[3], 0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("wr_rs_idle3", tick[3], 0);
         chk("wr_rs_ibusy3", busy[3], 0);
      end
      restart = 4'b1000;
      step();
      restart = 4'h0;
      chk("ch3_arm_busy", busy[3], 1);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("ch3_tick", tick[3], k == 3);
         chk("ch3_busy", busy[3], k <= 2);
      end

      // Reset mid-countdown, then defaults (periodic, div=1) return.
      restart = 4'b1000;
      step();
      restart = 4'h0;
      step();
      chk("pre_rst_busy3", busy[3], 1);
      rst = 1'b1;
      step();
      chk("mid_rst_tick", tick, 0);
      chk("mid_rst_busy", busy, 0);
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("post_rst_tick", tick, (k == 3 || k == 5) ? 4'hF : 4'h0);
         chk("post_rst_busy", busy, 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/prescaler_multi.md
Name: prescaler_multi

Overview:
- Multi-channel, runtime-programmable successor of the single fixed-divisor prescaler.
- CHANNELS independent counters each generate a one-cycle enable pulse on `tick[i]` every DIV+1 clocks.
- Per-channel divisor and mode (periodic / one-shot) are written at run time over a simple write port.
- Drives LED-matrix row scan, PWM bit-plane timing and refresh strobes from one clock domain.

Parameters:
- CHANNELS, 4: number of independent channels (1..16).
- WIDTH, 16: divisor/counter width in bits.
- SEL_BITS, 2: width of `cfg_sel`; must satisfy 2^SEL_BITS >= CHANNELS.
- DEFAULT_DIV, 1: divisor loaded into every channel at reset; must fit in WIDTH bits.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- run  in  CHANNELS  per-channel count enable; 0 freezes the counter.
- restart  in  CHANNELS  per-channel synchronous counter restart / one-shot trigger.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  SEL_BITS  channel index for the write.
- cfg_div  in  WIDTH  new divisor D (period = D+1 active cycles).
- cfg_mode  in  1  0 = periodic, 1 = one-shot.
- tick  out  CHANNELS  registered one-cycle pulse per channel.
- busy  out  CHANNELS  registered; 1 while a one-shot countdown is in progress.

Behaviour:
- Reset (`rst`=1 at posedge), all channels:
  - cnt=0, div=DEFAULT_DIV, mode=periodic, state=IDLE.
  - tick=0, busy=0.
  - `rst` overrides every other input.
- Per-channel state machine: IDLE, COUNT.
  - Periodic mode lives permanently in COUNT. Reset places every channel in IDLE, and a periodic channel leaves it on the first posedge with `rst`=0.
  - One-shot mode uses IDLE and COUNT.
- Active cycle: `run[i]`=1 and the channel is in COUNT.
- On an active cycle:
  - If cnt==div: `tick[i]`<=1 and cnt<=0. In one-shot mode also state<=IDLE and busy<=0.
  - Otherwise: cnt<=cnt+1 (WIDTH-bit, never wraps because cnt<=div) and tick<=0.
- Non-active cycle: cnt holds, tick<=0.
- Latency: with div=D and `run` held high, the first tick is registered at the (D+1)th active edge, then every D+1 active edges. D=0 gives tick high on every active cycle.
- `restart[i]`=1:
  - Sets cnt<=0 and tick<=0.
  - One-shot: state<=COUNT, busy<=1.
  - Periodic: the phase realigns.
  - Restart beats a same-cycle terminal count: no tick is produced.
- Config write (`cfg_we`=1 and `cfg_sel`<CHANNELS):
  - div<=cfg_div, mode<=cfg_mode, cnt<=0, tick<=0.
  - state<=IDLE for one-shot, COUNT for periodic; busy<=0.
  - The write beats a same-cycle `restart` on that channel; restart on other channels is unaffected.
  - `cfg_sel`>=CHANNELS: write ignored, no state change.
- Restart in one-shot while busy: re-arms from 0 and produces one tick only.
- Dropping `run` mid-count pauses the count without losing progress.

Optional Feature:
- Macro: PRESCALER_CASCADE_EN.
- Defined: channel i>0 treats a cycle as active only when `run[i]`=1, it is in COUNT, and `tick[i-1]`=1 (the registered output). Channel i therefore divides channel i-1's tick rate by div_i+1. Channel 0 is unchanged.
- Undefined: all channels count `clk` independently; no inter-channel path.

Test Plan:
- Reset, DEFAULT_DIV=1, run=all 1 -> each `tick` high on edges 2,4,6…; busy=0 throughout.
- Write ch2 div=4 periodic, run[2]=1 -> tick[2] pulses every 5 cycles, first 5 cycles after write; other channels keep period 2.
- Ch1 one-shot div=3, pulse restart[1] -> busy[1]=1 for 4 cycles, single tick[1] on 4th active edge, then busy=0 and no further ticks.
- Ch0 div=5, run[0] low for 3 cycles mid-count -> tick[0] delayed by exactly 3 cycles; restart on a terminal-count cycle -> no tick, next tick 6 cycles later. cfg_we with cfg_sel=5 (CHANNELS=4) -> no change.
- Same-cycle cfg_we and restart on ch3 -> new div applied, one-shot stays IDLE (busy=0). `rst` mid-count -> all outputs 0 next cycle, div back to DEFAULT_DIV.
- PRESCALER_CASCADE_EN, ch0 div=1, ch1 div=2 -> tick[1] every 6 clocks, coincident-plus-one with every third tick[0].
